// File: rtl/dcache_pkg.sv
// Shared constants and types for the 2-way data cache controller.
// Address layout: tag [31:9], set index [8:5], word select [4:2], byte [1:0].
// Tag word layout: {valid, dirty, tag[22:0]}.
package dcache_pkg;
    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int WORDS     = LINE_W / WORD_W;
    localparam int WSEL_W    = 3;
    localparam int OFF_W     = 5;
    localparam int IDX_W     = 4;
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int TAGWORD_W = TAG_W + 2;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_e;
endpackage

// File: rtl/dcache_2way_ctrl_if.sv
// Bundle of CPU, cache SRAM and backing memory signals around the controller.
// Signal names are from the controller's point of view (_i = into the controller).
// master: the controller. slave: CPU/SRAM/memory environment.
// Handshake: the CPU holds cpu_req_i/addr/data/we stable while cpu_stall_o is 1;
// the controller holds mem_enable_o and its address/data until a one-cycle
// mem_ack_i pulse, which completes the transfer on that clock edge.
// state_dbg exposes the controller FSM state for observation.
interface dcache_2way_ctrl_if;
    import dcache_pkg::*;

    logic                   cpu_req_i;
    logic                   cpu_we_i;
    logic [ADDR_W-1:0]      cpu_addr_i;
    logic [WORD_W-1:0]      cpu_data_i;
    logic [WORD_W-1:0]      cpu_data_o;
    logic                   cpu_stall_o;
    logic                   sram_enable_o;
    logic                   sram_write_o;
    logic [IDX_W-1:0]       sram_addr_o;
    logic [TAGWORD_W-1:0]   sram_tag_o;
    logic [LINE_W-1:0]      sram_data_o;
    logic [TAGWORD_W-1:0]   sram_tag_i;
    logic [LINE_W-1:0]      sram_data_i;
    logic                   sram_hit_i;
    logic                   mem_enable_o;
    logic                   mem_write_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [LINE_W-1:0]      mem_data_o;
    logic [LINE_W-1:0]      mem_data_i;
    logic                   mem_ack_i;
    state_e                 state_dbg;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o,
        output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output state_dbg
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  state_dbg
    );
endinterface

// File: rtl/dcache_word_merge.sv
// Combinational word extract and word insert on a cache line.
// line_i : 256-bit line        wsel_i : word index (address bits [4:2])
// word_i : word to insert      word_o : selected word of line_i
// line_o : line_i with the selected word replaced by word_i
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WSEL_W-1:0] wsel_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LINE_W-1:0] line_o
);
    always_comb begin
        word_o = '0;
        line_o = line_i;
        for (int i = 0; i < WORDS; i++) begin
            if (wsel_i == WSEL_W'(i)) begin
                word_o = line_i[i*WORD_W +: WORD_W];
                line_o[i*WORD_W +: WORD_W] = word_i;
            end
        end
    end
endmodule

// File: rtl/dcache_2way_ctrl.sv
// Sequencing controller between the CPU memory stage, a 2-way set-associative
// data cache SRAM and backing memory. Hits complete in the lookup cycle; misses
// stall the CPU, write back a dirty victim, fetch the line and refill the SRAM,
// after which the held request is replayed as a hit.
// Ports: clk_i, rst_i (synchronous, active-high), bus (dcache_2way_ctrl_if.master).
module dcache_2way_ctrl
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_2way_ctrl_if.master bus
);
    state_e              state_q, state_d;
    logic [TAG_W-1:0]    victim_tag_q, victim_tag_d;
    logic [LINE_W-1:0]   victim_line_q, victim_line_d;
    logic [LINE_W-1:0]   refill_q, refill_d;

    logic [TAG_W-1:0]    cpu_tag;
    logic [IDX_W-1:0]    cpu_idx;
    logic [WSEL_W-1:0]   cpu_wsel;
    logic [WORD_W-1:0]   hit_word;
    logic [LINE_W-1:0]   merged_line;
    logic                unused_byte_off;

    assign cpu_tag         = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_idx         = bus.cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_wsel        = bus.cpu_addr_i[2 +: WSEL_W];
    assign unused_byte_off = ^bus.cpu_addr_i[1:0];
    assign bus.state_dbg   = state_q;

    dcache_word_merge u_word_merge (
        .line_i (bus.sram_data_i),
        .wsel_i (cpu_wsel),
        .word_i (bus.cpu_data_i),
        .word_o (hit_word),
        .line_o (merged_line)
    );

    always_comb begin
        state_d       = state_q;
        victim_tag_d  = victim_tag_q;
        victim_line_d = victim_line_q;
        refill_d      = refill_q;

        bus.cpu_data_o    = '0;
        bus.cpu_stall_o   = 1'b1;
        bus.sram_enable_o = 1'b1;
        bus.sram_write_o  = 1'b0;
        bus.sram_addr_o   = cpu_idx;
        bus.sram_tag_o    = '0;
        bus.sram_data_o   = '0;
        bus.mem_enable_o  = 1'b0;
        bus.mem_write_o   = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_data_o    = '0;

        case (state_q)
            IDLE: begin
                bus.sram_enable_o = bus.cpu_req_i;
                bus.cpu_stall_o   = bus.cpu_req_i & ~bus.sram_hit_i;
                if (bus.cpu_req_i) begin
                    if (bus.sram_hit_i) begin
                        if (bus.cpu_we_i) begin
                            // Store hit: merged line commits on this edge, line becomes dirty.
                            bus.sram_write_o = 1'b1;
                            bus.sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                            bus.sram_data_o  = merged_line;
                        end else begin
                            bus.cpu_data_o = hit_word;
                        end
                    end else begin
                        // On a miss the SRAM presents the victim way it has chosen.
                        victim_tag_d  = bus.sram_tag_i[TAG_W-1:0];
                        victim_line_d = bus.sram_data_i;
                        if (bus.sram_tag_i[VALID_BIT] && bus.sram_tag_i[DIRTY_BIT]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = ALLOCATE;
                        end
                    end
                end
            end
            WRITEBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {victim_tag_q, cpu_idx, {OFF_W{1'b0}}};
                bus.mem_data_o   = victim_line_q;
                if (bus.mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
                if (bus.mem_ack_i) begin
                    refill_d = bus.mem_data_i;
                    state_d  = REFILL;
                end
            end
            REFILL: begin
                // Installed clean; a replayed store then merges as a normal write hit.
                bus.sram_write_o = 1'b1;
                bus.sram_tag_o   = {1'b1, 1'b0, cpu_tag};
                bus.sram_data_o  = refill_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle abandons any memory request and must not corrupt the SRAM.
        if (rst_i) begin
            bus.sram_write_o = 1'b0;
            bus.mem_enable_o = 1'b0;
            bus.mem_write_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            victim_tag_q  <= '0;
            victim_line_q <= '0;
            refill_q      <= '0;
        end else begin
            state_q       <= state_d;
            victim_tag_q  <= victim_tag_d;
            victim_line_q <= victim_line_d;
            refill_q      <= refill_d;
        end
    end
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed bench for dcache_2way_ctrl with a behavioural 2-way SRAM and a
// latency-programmable backing memory.
module tb_dcache_2way_ctrl;
    import dcache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    dcache_2way_ctrl_if bus ();

    dcache_2way_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    // ---------------- behavioural 2-way SRAM ----------------
    logic [24:0]  tag_mem [16][2];
    logic [255:0] dat_mem [16][2];
    logic         lru     [16];
    logic [3:0]   s_idx;
    logic [22:0]  s_tag;
    logic         h0, h1, sel_way;
    int           wr_cnt = 0;
    logic [24:0]  last_wr_tag;
    logic [255:0] last_wr_data;
    logic [3:0]   last_wr_addr;

    always_comb begin
        s_idx   = bus.sram_addr_o;
        s_tag   = bus.cpu_addr_i[31:9];
        h0      = tag_mem[s_idx][0][24] && (tag_mem[s_idx][0][22:0] == s_tag);
        h1      = tag_mem[s_idx][1][24] && (tag_mem[s_idx][1][22:0] == s_tag);
        sel_way = 1'b0;
        if (h0)                          sel_way = 1'b0;
        else if (h1)                     sel_way = 1'b1;
        else if (!tag_mem[s_idx][0][24]) sel_way = 1'b0;
        else if (!tag_mem[s_idx][1][24]) sel_way = 1'b1;
        else                             sel_way = lru[s_idx];
        bus.sram_hit_i  = 1'b0;
        bus.sram_tag_i  = '0;
        bus.sram_data_i = '0;
        if (bus.sram_enable_o) begin
            bus.sram_hit_i  = h0 | h1;
            bus.sram_tag_i  = tag_mem[s_idx][sel_way];
            bus.sram_data_i = dat_mem[s_idx][sel_way];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 16; s++) begin
                tag_mem[s][0] <= '0; tag_mem[s][1] <= '0;
                dat_mem[s][0] <= '0; dat_mem[s][1] <= '0;
                lru[s] <= 1'b0;
            end
        end else if (bus.sram_write_o) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_tag  <= bus.sram_tag_o;
            last_wr_data <= bus.sram_data_o;
            last_wr_addr <= bus.sram_addr_o;
            tag_mem[s_idx][sel_way] <= bus.sram_tag_o;
            dat_mem[s_idx][sel_way] <= bus.sram_data_o;
            lru[s_idx] <= ~sel_way;
        end else if (bus.sram_enable_o && bus.sram_hit_i) begin
            lru[s_idx] <= ~sel_way;
        end
    end

    // ---------------- backing memory: ack after lmem enabled cycles ----------------
    int           lmem = 3;
    int           mcnt = 0;
    logic         spur_ack = 1'b0;
    logic [255:0] mem_rdata = '0;
    int           wb_cnt = 0;
    int           fetch_cnt = 0;
    logic [31:0]  wb_addr = '0, fetch_addr = '0;
    logic [255:0] wb_data = '0;

    always @(negedge clk) begin
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        if (bus.mem_enable_o) begin
            mcnt = mcnt + 1;
            if (mcnt >= lmem) begin
                mcnt = 0;
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = mem_rdata;
                if (bus.mem_write_o) begin
                    wb_cnt  = wb_cnt + 1;
                    wb_addr = bus.mem_addr_o;
                    wb_data = bus.mem_data_o;
                end else begin
                    fetch_cnt  = fetch_cnt + 1;
                    fetch_addr = bus.mem_addr_o;
                end
            end
        end else begin
            mcnt = 0;
            bus.mem_ack_i = spur_ack;
        end
    end

    // ---------------- state trace (scoreboard of non-IDLE states) ----------------
    logic [1:0] trace_q[$];
    logic [1:0] exp_q[$];
    int         bad_nonidle = 0;

    always @(negedge clk) begin
        if (!rst && bus.state_dbg != IDLE) begin
            trace_q.push_back(bus.state_dbg);
            if (!bus.cpu_stall_o || !bus.sram_enable_o) bad_nonidle = bad_nonidle + 1;
        end
    end

    function automatic bit trace_matches();
        if (trace_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (trace_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // ---------------- driver ----------------
    task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          output int stall, output logic [31:0] rdata);
        @(negedge clk);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = addr;
        bus.cpu_data_i = wdata;
        stall = 0;
        rdata = '0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!bus.cpu_stall_o) begin
                rdata = bus.cpu_data_o;
                break;
            end
            stall++;
            @(negedge clk);
        end
        checks++;
        if (bus.cpu_stall_o) begin
            failures++;
            $display("FAIL access_timeout addr=%h still stalled after 200 cycles", addr);
        end
        @(posedge clk);
        #1;
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
    endtask

    // ---------------- tests ----------------
    logic [255:0] line1, line2, line3, line4, line5, dirty1;

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (bus.state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, IDLE); end
        checks++; if (bus.cpu_stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall_req got=%b exp=1", bus.cpu_stall_o); end
        checks++; if (bus.mem_enable_o !== 1'b0 || bus.sram_write_o !== 1'b0) begin failures++; $display("FAIL reset_strobes mem_en=%b sram_wr=%b exp=0/0", bus.mem_enable_o, bus.sram_write_o); end
        checks++; if (bus.cpu_data_o !== 32'h0 || bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_data cpu_data=%h mem_addr=%h exp=0", bus.cpu_data_o, bus.mem_addr_o); end
        rst = 1'b0;
        bus.cpu_req_i = 1'b0;
        #1;
        checks++; if (bus.cpu_stall_o !== 1'b0 || bus.sram_enable_o !== 1'b0) begin failures++; $display("FAIL idle_noreq stall=%b sram_en=%b exp=0/0", bus.cpu_stall_o, bus.sram_enable_o); end
    endtask

    task automatic test_cold_read();
        int st; logic [31:0] rd; int w0, f0;
        lmem = 3; mem_rdata = line1; w0 = wr_cnt; f0 = fetch_cnt;
        trace_q.delete(); exp_q.delete();
        exp_q = '{ALLOCATE, ALLOCATE, ALLOCATE, REFILL};
        access(32'h0000_0124, 1'b0, 32'h0, st, rd);
        checks++; if (st != 5) begin failures++; $display("FAIL cold_stall got=%0d exp=5", st); end
        checks++; if (rd !== 32'h1111_1111) begin failures++; $display("FAIL cold_data got=%h exp=11111111", rd); end
        checks++; if (!trace_matches()) begin failures++; $display("FAIL cold_trace got_len=%0d exp_len=%0d", trace_q.size(), exp_q.size()); end
        checks++; if (wr_cnt != w0 + 1 || last_wr_tag !== 25'h100_0000 || last_wr_addr !== 4'd9) begin failures++; $display("FAIL cold_refill_tag writes=%0d tag=%h set=%0d exp=1/1000000/9", wr_cnt - w0, last_wr_tag, last_wr_addr); end
        checks++; if (last_wr_data !== line1) begin failures++; $display("FAIL cold_refill_data got=%h exp=%h", last_wr_data, line1); end
        checks++; if (fetch_cnt != f0 + 1 || fetch_addr !== 32'h0000_0120) begin failures++; $display("FAIL cold_fetch n=%0d addr=%h exp=1/00000120", fetch_cnt - f0, fetch_addr); end
    endtask

    task automatic test_store_hit();
        int st; logic [31:0] rd; int w0;
        w0 = wr_cnt;
        access(32'h0000_0128, 1'b1, 32'hDEAD_BEEF, st, rd);
        checks++; if (st != 0) begin failures++; $display("FAIL store_stall got=%0d exp=0", st); end
        checks++; if (wr_cnt != w0 + 1 || last_wr_tag !== 25'h180_0000) begin failures++; $display("FAIL store_tag writes=%0d tag=%h exp=1/1800000", wr_cnt - w0, last_wr_tag); end
        checks++; if (last_wr_data !== dirty1) begin failures++; $display("FAIL store_line got=%h exp=%h", last_wr_data, dirty1); end
        access(32'h0000_0128, 1'b0, 32'h0, st, rd);
        checks++; if (st != 0 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_readback stall=%0d data=%h exp=0/deadbeef", st, rd); end
        access(32'h0000_0124, 1'b0, 32'h0, st, rd);
        checks++; if (st != 0 || rd !== 32'h1111_1111 || wr_cnt != w0 + 1) begin failures++; $display("FAIL neighbour_read stall=%0d data=%h writes=%0d exp=0/11111111/1", st, rd, wr_cnt - w0); end
    endtask

    task automatic test_dirty_victim();
        int st; logic [31:0] rd; int wb0;
        lmem = 3; mem_rdata = line2;
        access(32'h0000_0320, 1'b0, 32'h0, st, rd);
        checks++; if (st != 5 || rd !== 32'h2222_2220) begin failures++; $display("FAIL fill_way1 stall=%0d data=%h exp=5/22222220", st, rd); end
        mem_rdata = line3; wb0 = wb_cnt;
        trace_q.delete(); exp_q.delete();
        exp_q = '{WRITEBACK, WRITEBACK, WRITEBACK, ALLOCATE, ALLOCATE, ALLOCATE, REFILL};
        access(32'h0000_0520, 1'b0, 32'h0, st, rd);
        checks++; if (st != 8) begin failures++; $display("FAIL dirty_stall got=%0d exp=8", st); end
        checks++; if (wb_cnt != wb0 + 1 || wb_addr !== 32'h0000_0120) begin failures++; $display("FAIL wb_addr n=%0d addr=%h exp=1/00000120", wb_cnt - wb0, wb_addr); end
        checks++; if (wb_data !== dirty1) begin failures++; $display("FAIL wb_data got=%h exp=%h", wb_data, dirty1); end
        checks++; if (fetch_addr !== 32'h0000_0520 || rd !== 32'h3333_3330) begin failures++; $display("FAIL dirty_fetch addr=%h data=%h exp=00000520/33333330", fetch_addr, rd); end
        checks++; if (!trace_matches()) begin failures++; $display("FAIL dirty_trace got_len=%0d exp_len=%0d", trace_q.size(), exp_q.size()); end
    endtask

    task automatic test_clean_victim();
        int st; logic [31:0] rd; int wb0, f0;
        lmem = 1; mem_rdata = line4; wb0 = wb_cnt; f0 = fetch_cnt;
        trace_q.delete(); exp_q.delete();
        exp_q = '{ALLOCATE, REFILL};
        access(32'h0000_0724, 1'b0, 32'h0, st, rd);
        checks++; if (st != 3 || rd !== 32'h4444_4441) begin failures++; $display("FAIL clean_stall_data stall=%0d data=%h exp=3/44444441", st, rd); end
        checks++; if (wb_cnt != wb0 || fetch_cnt != f0 + 1 || fetch_addr !== 32'h0000_0720) begin failures++; $display("FAIL clean_mem wb=%0d fetch=%0d addr=%h exp=0/1/00000720", wb_cnt - wb0, fetch_cnt - f0, fetch_addr); end
        checks++; if (!trace_matches()) begin failures++; $display("FAIL clean_trace got_len=%0d exp_len=%0d", trace_q.size(), exp_q.size()); end
    endtask

    task automatic test_spurious_and_drop();
        int w0, f0; bit done;
        w0 = wr_cnt; f0 = fetch_cnt;
        @(posedge clk); #1 spur_ack = 1'b1;
        @(posedge clk); #1 spur_ack = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.state_dbg !== IDLE || bus.mem_enable_o !== 1'b0 || wr_cnt != w0 || fetch_cnt != f0) begin failures++; $display("FAIL spurious_ack state=%0d mem_en=%b writes=%0d exp=0/0/0", bus.state_dbg, bus.mem_enable_o, wr_cnt - w0); end
        lmem = 4; mem_rdata = line5;
        trace_q.delete(); exp_q.delete();
        exp_q = '{ALLOCATE, ALLOCATE, ALLOCATE, ALLOCATE, REFILL};
        @(negedge clk);
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0048;
        @(negedge clk); #1;
        checks++; if (bus.state_dbg !== ALLOCATE) begin failures++; $display("FAIL drop_enter state=%0d exp=%0d", bus.state_dbg, ALLOCATE); end
        bus.cpu_req_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.state_dbg == IDLE) begin done = 1'b1; break; end
        end
        checks++; if (!done) begin failures++; $display("FAIL drop_return state=%0d exp=%0d", bus.state_dbg, IDLE); end
        checks++; if (wr_cnt != w0 + 1 || last_wr_tag !== 25'h100_0000 || last_wr_addr !== 4'd2 || last_wr_data !== line5) begin failures++; $display("FAIL drop_refill writes=%0d tag=%h set=%0d exp=1/1000000/2", wr_cnt - w0, last_wr_tag, last_wr_addr); end
        checks++; if (!trace_matches()) begin failures++; $display("FAIL drop_trace got_len=%0d exp_len=%0d", trace_q.size(), exp_q.size()); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wr_cnt != w0 + 1 || bus.state_dbg !== IDLE || bus.cpu_stall_o !== 1'b0) begin failures++; $display("FAIL drop_quiet writes=%0d state=%0d stall=%b exp=1/0/0", wr_cnt - w0, bus.state_dbg, bus.cpu_stall_o); end
    endtask

    task automatic test_reset_in_writeback();
        int st; logic [31:0] rd; int wb0;
        access(32'h0000_0048, 1'b1, 32'hCAFE_F00D, st, rd);
        lmem = 1; mem_rdata = line2;
        access(32'h0000_0248, 1'b0, 32'h0, st, rd);
        checks++; if (st != 3) begin failures++; $display("FAIL pre_reset_fill stall=%0d exp=3", st); end
        lmem = 10; wb0 = wb_cnt;
        @(negedge clk);
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0448;
        @(negedge clk); #1;
        checks++; if (bus.state_dbg !== WRITEBACK || bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b1) begin failures++; $display("FAIL wb_enter state=%0d mem_en=%b mem_wr=%b exp=1/1/1", bus.state_dbg, bus.mem_enable_o, bus.mem_write_o); end
        @(negedge clk);
        rst = 1'b1; bus.cpu_req_i = 1'b0;
        #1;
        checks++; if (bus.sram_write_o !== 1'b0) begin failures++; $display("FAIL rst_cycle_sram_write got=%b exp=0", bus.sram_write_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.state_dbg !== IDLE || bus.mem_enable_o !== 1'b0 || bus.sram_write_o !== 1'b0) begin failures++; $display("FAIL after_rst state=%0d mem_en=%b sram_wr=%b exp=0/0/0", bus.state_dbg, bus.mem_enable_o, bus.sram_write_o); end
        repeat (12) @(negedge clk);
        #1;
        checks++; if (wb_cnt != wb0 || bus.state_dbg !== IDLE) begin failures++; $display("FAIL abandoned_wb wb=%0d state=%0d exp=0/0", wb_cnt - wb0, bus.state_dbg); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0124;
        bus.cpu_data_i = 32'h0;
        line1  = mk_line(32'h1111_1110);
        line2  = mk_line(32'h2222_2220);
        line3  = mk_line(32'h3333_3330);
        line4  = mk_line(32'h4444_4440);
        line5  = mk_line(32'h5555_5550);
        dirty1 = line1;
        dirty1[95:64] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        test_reset();
        test_cold_read();
        test_store_hit();
        test_dirty_victim();
        test_clean_victim();
        test_spurious_and_drop();
        checks++; if (bad_nonidle != 0) begin failures++; $display("FAIL nonidle_stall_enable bad_cycles=%0d exp=0", bad_nonidle); end
        test_reset_in_writeback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
